// File: rtl/aes_wb_pkg.sv
// Shared definitions for the aes128 Wishbone host: register offsets,
// control/status bit positions and the sequencer state type.
package aes_wb_pkg;

  localparam logic [7:0] KEY0_OFF   = 8'h00;
  localparam logic [7:0] KEY1_OFF   = 8'h04;
  localparam logic [7:0] KEY2_OFF   = 8'h08;
  localparam logic [7:0] KEY3_OFF   = 8'h0C;
  localparam logic [7:0] PT0_OFF    = 8'h10;
  localparam logic [7:0] PT1_OFF    = 8'h14;
  localparam logic [7:0] PT2_OFF    = 8'h18;
  localparam logic [7:0] PT3_OFF    = 8'h1C;
  localparam logic [7:0] CTRL_OFF   = 8'h20;
  localparam logic [7:0] STATUS_OFF = 8'h24;
  localparam logic [7:0] CT0_OFF    = 8'h30;
  localparam logic [7:0] CT1_OFF    = 8'h34;
  localparam logic [7:0] CT2_OFF    = 8'h38;
  localparam logic [7:0] CT3_OFF    = 8'h3C;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Merge a write word into an existing register honouring byte enables.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_wb_seq.sv
// Encryption sequencer: IDLE/RUN FSM, latency counter, capture strobe and
// the sticky done flag.
module aes_wb_seq
  import aes_wb_pkg::*;
#(
  parameter int unsigned AES_LATENCY = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  input  logic done_clr,
  output logic busy,
  output logic done,
  output logic capture
);

  seq_state_t  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  // State, counter and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state, countdown and capture decision; completion beats a
  // coincident done clear, a fresh start clears done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = RUN;
          cnt_d   = 8'(AES_LATENCY);
        end
      end
      RUN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          capture = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE && start_req) done_d = 1'b0;
    else if (capture)                 done_d = 1'b1;
    else if (done_clr)                done_d = 1'b0;
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: rtl/aes128_wb_host.sv
// Wishbone B4 classic slave hosting the aes128 core: key/plaintext
// registers, start control, ciphertext capture and completion interrupt.
module aes128_wb_host
  import aes_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned AES_LATENCY = 21
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [127:0] aes_key,
  output logic [127:0] aes_state,
  input  logic [127:0] aes_out,
  output logic         irq_o
);

  logic [31:0] key_q [4];
  logic [31:0] pt_q  [4];
  logic [31:0] ct_q  [4];
  logic        irq_en_q;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rdata;
  logic [7:0]  off;
  logic [1:0]  widx;
  logic        in_window, accept, wr_acc;
  logic        start_req, done_clr;
  logic        busy, done, capture;
  logic        unused_adr_bits;

  assign in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign accept    = wbs_cyc_i & wbs_stb_i & in_window & ~ack_q;
  assign wr_acc    = accept & wbs_we_i;
  assign off       = {wbs_adr_i[7:2], 2'b00};
  assign widx      = wbs_adr_i[3:2];
  assign unused_adr_bits = ^wbs_adr_i[1:0];

  assign start_req = wr_acc && (off == CTRL_OFF) && wbs_sel_i[0]
                     && wbs_dat_i[CTRL_START_BIT];
  assign done_clr  = wr_acc && (off == STATUS_OFF) && wbs_sel_i[0]
                     && wbs_dat_i[STATUS_DONE_BIT];

  aes_wb_seq #(
    .AES_LATENCY(AES_LATENCY)
  ) u_seq (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .start_req(start_req),
    .done_clr (done_clr),
    .busy     (busy),
    .done     (done),
    .capture  (capture)
  );

  // Host-writable registers; key/plaintext frozen while the core runs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        key_q[i] <= '0;
        pt_q[i]  <= '0;
      end
      irq_en_q <= 1'b0;
    end else if (wr_acc) begin
      if (!busy && off[7:4] == KEY0_OFF[7:4])
        key_q[widx] <= apply_sel(key_q[widx], wbs_dat_i, wbs_sel_i);
      if (!busy && off[7:4] == PT0_OFF[7:4])
        pt_q[widx] <= apply_sel(pt_q[widx], wbs_dat_i, wbs_sel_i);
      if (off == CTRL_OFF && wbs_sel_i[0])
        irq_en_q <= wbs_dat_i[CTRL_IRQ_EN_BIT];
    end
  end

  // Ciphertext capture on the sequencer's completion strobe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < 4; i++) ct_q[i] <= '0;
    end else if (capture) begin
      ct_q[0] <= aes_out[127:96];
      ct_q[1] <= aes_out[95:64];
      ct_q[2] <= aes_out[63:32];
      ct_q[3] <= aes_out[31:0];
    end
  end

  // Read mux; unmapped in-window offsets return zero.
  always_comb begin
    rdata = '0;
    unique case (off[7:4])
      KEY0_OFF[7:4]: rdata = key_q[widx];
      PT0_OFF[7:4]:  rdata = pt_q[widx];
      CT0_OFF[7:4]:  rdata = ct_q[widx];
      CTRL_OFF[7:4]: begin
        if (off == CTRL_OFF) begin
          rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
        end else if (off == STATUS_OFF) begin
          rdata[STATUS_BUSY_BIT] = busy;
          rdata[STATUS_DONE_BIT] = done;
        end
      end
      default: rdata = '0;
    endcase
  end

  // Registered single-cycle ack with read data aligned to it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= accept;
      dat_q <= (accept && !wbs_we_i) ? rdata : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign aes_key   = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_state = {pt_q[0], pt_q[1], pt_q[2], pt_q[3]};
  assign irq_o     = done & irq_en_q;

endmodule

// File: tb/tb_aes128_wb_host.sv
// Directed bench for aes128_wb_host with a pipelined stand-in for the core.
module tb_aes128_wb_host;

  localparam int unsigned  LAT  = 21;
  localparam logic [31:0]  BASE = 32'h3000_0000;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [127:0] aes_key, aes_state, aes_out;
  logic         irq;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  aes128_wb_host #(
    .BASE_ADDR  (BASE),
    .AES_LATENCY(LAT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .aes_key  (aes_key),
    .aes_state(aes_state),
    .aes_out  (aes_out),
    .irq_o    (irq)
  );

  // Core stand-in: LAT-deep pipeline, FIPS-197 answer for the FIPS inputs.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] s);
    if (k == FIPS_KEY && s == FIPS_PT) return FIPS_CT;
    return k ^ {s[63:0], s[127:64]} ^ 128'h5a5a;
  endfunction

  logic [127:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= core_f(aes_key, aes_state);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign aes_out = pipe[LAT-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic acked);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    logic        acked;
    xfer(BASE + off, 1'b1, d, s, rd, acked);
    check($sformatf("wr_ack_%h", off), acked, 1);
  endtask

  task automatic rdw(input logic [31:0] off, output logic [31:0] d);
    logic acked;
    xfer(BASE + off, 1'b0, '0, 4'hf, d, acked);
    check($sformatf("rd_ack_%h", off), acked, 1);
  endtask

  task automatic load_fips();
    for (int i = 0; i < 4; i++) begin
      wr(32'(i*4), FIPS_KEY[127 - i*32 -: 32], 4'hf);
      wr(32'(16 + i*4), FIPS_PT[127 - i*32 -: 32], 4'hf);
    end
  endtask

  task automatic wait_done_poll(input string name);
    logic [31:0] d;
    logic        seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      rdw(32'h24, d);
      if (d[1]) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  task automatic check_ct(input string name, input logic [127:0] exp);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      rdw(32'(32'h30 + i*4), d);
      check($sformatf("%s_ct%0d", name, i), d, exp[127 - i*32 -: 32]);
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] off;
    logic        w;
    logic [31:0] dat;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        acked;
    int          n;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;

    vt.push_back('{"rst_key0",  32'h00, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"rst_status",32'h24, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"rst_ct0",   32'h30, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"rst_ctrl",  32'h20, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"w_key0",    32'h00, 1'b1, 32'h00010203,  4'hf, 32'h0});
    vt.push_back('{"w_key1",    32'h04, 1'b1, 32'h04050607,  4'hf, 32'h0});
    vt.push_back('{"w_key2",    32'h08, 1'b1, 32'h08090a0b,  4'hf, 32'h0});
    vt.push_back('{"w_key3",    32'h0C, 1'b1, 32'h0c0d0e0f,  4'hf, 32'h0});
    vt.push_back('{"w_pt0",     32'h10, 1'b1, 32'h00112233,  4'hf, 32'h0});
    vt.push_back('{"w_pt1",     32'h14, 1'b1, 32'h00000000,  4'hf, 32'h0});
    vt.push_back('{"w_pt2",     32'h18, 1'b1, 32'h8899aabb,  4'hf, 32'h0});
    vt.push_back('{"w_pt3",     32'h1C, 1'b1, 32'hccddeeff,  4'hf, 32'h0});
    vt.push_back('{"r_key0",    32'h00, 1'b0, 32'h0,         4'hf, 32'h00010203});
    vt.push_back('{"r_key3",    32'h0C, 1'b0, 32'h0,         4'hf, 32'h0c0d0e0f});
    vt.push_back('{"r_pt0",     32'h10, 1'b0, 32'h0,         4'hf, 32'h00112233});
    vt.push_back('{"r_pt3",     32'h1C, 1'b0, 32'h0,         4'hf, 32'hccddeeff});
    vt.push_back('{"w_pt1_sel", 32'h14, 1'b1, 32'hAABBCCDD,  4'b0010, 32'h0});
    vt.push_back('{"r_pt1_sel", 32'h14, 1'b0, 32'h0,         4'hf, 32'h0000CC00});
    vt.push_back('{"w_pt1",     32'h14, 1'b1, 32'h44556677,  4'hf, 32'h0});
    vt.push_back('{"r_pt1",     32'h14, 1'b0, 32'h0,         4'hf, 32'h44556677});
    vt.push_back('{"w_ctrl_ie", 32'h20, 1'b1, 32'h00000002,  4'hf, 32'h0});
    vt.push_back('{"r_ctrl_ie", 32'h20, 1'b0, 32'h0,         4'hf, 32'h00000002});
    vt.push_back('{"w_ctrl_0",  32'h20, 1'b1, 32'h00000000,  4'hf, 32'h0});
    vt.push_back('{"r_ctrl_0",  32'h20, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"w_gap28",   32'h28, 1'b1, 32'hFFFFFFFF,  4'hf, 32'h0});
    vt.push_back('{"r_gap28",   32'h28, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"r_gap2c",   32'h2C, 1'b0, 32'h0,         4'hf, 32'h0});
    vt.push_back('{"w_ct0_ro",  32'h30, 1'b1, 32'hFFFFFFFF,  4'hf, 32'h0});
    vt.push_back('{"r_ct0_ro",  32'h30, 1'b0, 32'h0,         4'hf, 32'h0});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_irq", irq, 0);
    check("rst_aes_key", aes_key, 0);

    foreach (vt[i]) begin
      if (vt[i].w) begin
        wr(vt[i].off, vt[i].dat, vt[i].s);
      end else begin
        rdw(vt[i].off, d);
        check(vt[i].name, d, vt[i].exp);
      end
    end
    check("aes_key_fips", aes_key, FIPS_KEY);
    check("aes_state_fips", aes_state, FIPS_PT);

    // FIPS vector with interrupt disabled
    wr(32'h20, 32'h1, 4'hf);
    rdw(32'h24, d);
    check("busy_after_start", d, 32'h1);
    wait_done_poll("fips_done_seen");
    rdw(32'h24, d);
    check("fips_status", d, 32'h2);
    check_ct("fips", FIPS_CT);
    check("irq_masked", irq, 0);

    // Interrupt: enable with done pending, restart, measure latency
    wr(32'h20, 32'h2, 4'hf);
    check("irq_pending_on_enable", irq, 1);
    wr(32'h20, 32'h3, 4'hf);
    check("irq_cleared_by_start", irq, 0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (irq) begin
        n = i;
        break;
      end
    end
    check("irq_latency", n, LAT);
    wr(32'h24, 32'h2, 4'hf);
    @(posedge clk); #1;
    check("irq_after_w1c", irq, 0);
    rdw(32'h24, d);
    check("status_after_w1c", d, 32'h0);

    // Key write during RUN is discarded
    wr(32'h20, 32'h3, 4'hf);
    wr(32'h00, 32'hFFFFFFFF, 4'hf);
    rdw(32'h00, d);
    check("key0_frozen", d, 32'h00010203);
    check("aes_key_stable", aes_key, FIPS_KEY);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (irq) begin
        n = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("run2_irq_seen", n, 1);
    check_ct("run2", FIPS_CT);
    wr(32'h24, 32'h2, 4'hf);

    // Out-of-window request is ignored
    xfer(BASE + 32'h100, 1'b0, '0, 4'hf, d, acked);
    check("oow_no_ack", acked, 0);

    // Reset in the middle of a run
    wr(32'h20, 32'h1, 4'hf);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrun_rst_irq", irq, 0);
    rdw(32'h24, d);
    check("midrun_rst_status", d, 32'h0);
    repeat (LAT + 2) @(posedge clk);
    rdw(32'h24, d);
    check("midrun_rst_no_done", d, 32'h0);
    check_ct("midrun_rst", 128'h0);
    load_fips();
    wr(32'h20, 32'h1, 4'hf);
    wait_done_poll("post_rst_done_seen");
    check_ct("post_rst", FIPS_CT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
